alu_mp_seq: RTL and testbench

ALU_MP_SEQ -- requirements
Module: alu_mp_seq

---
 rtl/alu_mp_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_mp_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mp_seq.sv
// alu_mp_seq: multi-precision add/subtract sequencer.
// Splits WIDTH*WORDS-bit operands into WORDS limbs and walks them through an
// external single-limb ALU, least significant limb first, chaining the
// carry/borrow between limbs. The finished result, final carry/borrow and a
// zero flag are registered on the last limb. An ALU flag-valid drop aborts
// the operation and sets err.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, op_sub, opa, opb   request, 0=add/1=sub, operands
//   busy, done, err           status (done is a one-cycle pulse)
//   result, carry_out, zero   last completed result and flags
//   alu_instr/a/b/c_in/b_in   drive to the external ALU
//   alu_res/c_out/b_out       ALU result, carry out, borrow out
//   alu_flag_valid            ALU flags valid; low aborts the operation
//
// state | meaning
// IDLE  | waiting for start; ALU driven with NOP
// RUN   | one limb per cycle through the ALU
// DONE  | one-cycle completion/abort pulse

`ifndef NOP
`define NOP 4'h0
`endif
`ifndef ADD
`define ADD 4'h1
`endif
`ifndef SUB
`define SUB 4'h2
`endif

module alu_mp_seq #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 4,
  parameter int WORDS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [WIDTH*WORDS-1:0]   opa,
  input  logic [WIDTH*WORDS-1:0]   opb,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [WIDTH*WORDS-1:0]   result,
  output logic                     carry_out,
  output logic                     zero,
  output logic [IWIDTH-1:0]        alu_instr,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_c_in,
  output logic                     alu_b_in,
  input  logic [WIDTH-1:0]         alu_res,
  input  logic                     alu_c_out,
  input  logic                     alu_b_out,
  input  logic                     alu_flag_valid
);

  localparam int TW  = WIDTH * WORDS;
  localparam int IXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IXW-1:0]  idx_q, idx_d;
  logic            chain_q, chain_d;
  logic            sub_q, sub_d;
  logic [TW-1:0]   a_q, a_d;
  logic [TW-1:0]   b_q, b_d;
  logic [TW-1:0]   acc_q, acc_d;
  logic [TW-1:0]   result_q, result_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic [TW-1:0]   acc_wr;     // accumulator with the current limb merged in
  logic            chain_new;
  logic            last_limb;

  assign last_limb = (idx_q == IXW'(WORDS - 1));
  assign chain_new = sub_q ? alu_b_out : alu_c_out;

  always_comb begin
    acc_wr = acc_q;
    acc_wr[idx_q*WIDTH +: WIDTH] = alu_res;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    chain_d  = chain_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = opa;
          b_d     = opb;
          sub_d   = op_sub;
          idx_d   = '0;
          chain_d = 1'b0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        if (!alu_flag_valid) begin
          // abort keeps the previously completed result and flags
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          acc_d   = acc_wr;
          chain_d = chain_new;
          idx_d   = idx_q + IXW'(1);
          if (last_limb) begin
            state_d  = S_DONE;
            result_d = acc_wr;
            carry_d  = chain_new;
            zero_d   = (acc_wr == '0);
            err_d    = 1'b0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_instr = IWIDTH'(`NOP);
    alu_a     = '0;
    alu_b     = '0;
    alu_c_in  = 1'b0;
    alu_b_in  = 1'b0;
    if (state_q == S_RUN) begin
      alu_instr = sub_q ? IWIDTH'(`SUB) : IWIDTH'(`ADD);
      alu_a     = a_q[idx_q*WIDTH +: WIDTH];
      alu_b     = b_q[idx_q*WIDTH +: WIDTH];
      alu_c_in  = sub_q ? 1'b0 : chain_q;
      alu_b_in  = sub_q ? chain_q : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      chain_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      chain_q  <= chain_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mp_seq.sv
`ifndef NOP
`define NOP 4'h0
`endif
`ifndef ADD
`define ADD 4'h1
`endif
`ifndef SUB
`define SUB 4'h2
`endif

module tb_alu_mp_seq;

  localparam int WIDTH  = 8;
  localparam int IWIDTH = 4;
  localparam int WORDS  = 4;
  localparam int TW     = WIDTH * WORDS;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              op_sub;
  logic [TW-1:0]     opa, opb;
  logic              busy, done, err;
  logic [TW-1:0]     result;
  logic              carry_out, zero;
  logic [IWIDTH-1:0] alu_instr;
  logic [WIDTH-1:0]  alu_a, alu_b;
  logic              alu_c_in, alu_b_in;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c_out, alu_b_out;
  logic              alu_flag_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_mp_seq #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .err(err),
    .result(result), .carry_out(carry_out), .zero(zero),
    .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c_in(alu_c_in), .alu_b_in(alu_b_in), .alu_res(alu_res),
    .alu_c_out(alu_c_out), .alu_b_out(alu_b_out),
    .alu_flag_valid(alu_flag_valid)
  );

  // single-limb ALU attached to the sequencer
  always_comb begin
    logic [WIDTH:0] t;
    t = '0;
    alu_c_out = 1'b0;
    alu_b_out = 1'b0;
    if (alu_instr == IWIDTH'(`ADD)) begin
      t = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_c_in};
      alu_c_out = t[WIDTH];
    end else if (alu_instr == IWIDTH'(`SUB)) begin
      t = {1'b0, alu_a} - {1'b0, alu_b} - {{WIDTH{1'b0}}, alu_b_in};
      alu_b_out = t[WIDTH];
    end
    alu_res = t[WIDTH-1:0];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic sub, input logic [TW-1:0] a,
                        input logic [TW-1:0] b, input logic [TW-1:0] exp_r,
                        input logic exp_c, input logic exp_z);
    int lat;
    logic [IWIDTH-1:0] ei;
    wait_idle();
    ei = sub ? IWIDTH'(`SUB) : IWIDTH'(`ADD);
    opa = a; opb = b; op_sub = sub; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_instr"}, 64'(alu_instr), 64'(ei));
    check({tag, "_limb0_a"}, 64'(alu_a), 64'(a[7:0]));
    check({tag, "_limb0_b"}, 64'(alu_b), 64'(b[7:0]));
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_result"}, 64'(result), 64'(exp_r));
    check({tag, "_carry"}, 64'(carry_out), 64'(exp_c));
    check({tag, "_zero"}, 64'(zero), 64'(exp_z));
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_nop_done"}, 64'(alu_instr), 64'(IWIDTH'(`NOP)));
    tick();
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, last, ndone0;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; opa = '0; opb = '0;
    alu_flag_valid = 1'b1;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_instr", 64'(alu_instr), 64'(IWIDTH'(`NOP)));
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("add_ff_1", 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0);
    run_op("add_wrap", 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1);
    run_op("sub_100_1", 1'b1, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0);
    run_op("sub_0_1", 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0);

    // reset in the second RUN cycle
    wait_idle();
    opa = 32'hAAAAAAAA; opb = 32'h55555555; op_sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_alu_a_limb1", 64'(alu_a), 64'hAA);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_carry", 64'(carry_out), 64'd0);
    check("mid_rst_alu_a", 64'(alu_a), 64'd0);
    check("mid_rst_instr", 64'(alu_instr), 64'(IWIDTH'(`NOP)));
    tick();
    tick();
    rst = 1'b0;
    ndone0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone0++;
      tick();
    end
    check("mid_rst_no_done", 64'(ndone0), 64'd0);
    run_op("add_post_rst", 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0);

    // flag-valid drop in the third RUN cycle
    wait_idle();
    opa = 32'h00000001; opb = 32'h00000001; op_sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    alu_flag_valid = 1'b0;
    tick();
    alu_flag_valid = 1'b1;
    check("abort_done", 64'(done), 64'd1);
    check("abort_err", 64'(err), 64'd1);
    check("abort_result", 64'(result), 64'h23456789);
    check("abort_carry", 64'(carry_out), 64'd0);
    tick();
    check("abort_idle", 64'(busy), 64'd0);
    run_op("sub_clear_err", 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0);

    // start held high, operands toggled every cycle
    wait_idle();
    dones = 0;
    last = -1;
    start = 1'b1; op_sub = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        opa = 32'h01020304; opb = 32'h10203040;
      end else begin
        opa = 32'hFFFFFFFF; opb = 32'hFFFFFFFF;
      end
      @(negedge clk);
      if (done) begin
        dones++;
        check("stream_result", 64'(result), 64'h11223344);
        if (last >= 0) check("stream_period", 64'(i - last), 64'd6);
        last = i;
      end
      tick();
    end
    start = 1'b0;
    check("stream_count", 64'(dones), 64'd5);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
